// File: rtl/data_cache_pkg.sv
// ---------------------------------------------------------------------------
// data_cache_pkg
// Shared definitions for the direct-mapped write-back data cache:
//   - dc_state_e : controller states (idle / write-back / refill)
//   - line geometry: 4 words of 8 bytes per line
//   - bit positions of the word offset and the line index in a byte address
// ---------------------------------------------------------------------------
package data_cache_pkg;

  typedef enum logic [1:0] {
    DC_IDLE   = 2'd0,
    DC_WB     = 2'd1,
    DC_REFILL = 2'd2
  } dc_state_e;

  localparam int DC_WORDS   = 4;  // words per line
  localparam int DC_OFF_W   = 2;  // word-offset width
  localparam int DC_OFF_LSB = 3;  // word offset starts above the byte offset
  localparam int DC_IDX_LSB = 5;  // line index starts above the 32-byte line

endpackage

// File: rtl/data_cache_line_store.sv
// ---------------------------------------------------------------------------
// data_cache_line_store
// Storage for the cache: per-line data words, tag, valid and dirty bits.
//
// Ports
//   clk_i, rst_i       : clock, synchronous active-high reset (clears valid
//                        and dirty only; data and tags need no reset)
//   rd_idx_i/rd_off_i  : asynchronous read address (line, word)
//   rd_word_o          : selected data word
//   rd_tag_o/rd_valid_o/rd_dirty_o : metadata of line rd_idx_i
//   wr_en_i, wr_idx_i, wr_off_i, wr_data_i : single word-write port
//   meta_we_i, meta_idx_i, meta_tag_i, meta_valid_i, meta_dirty_i :
//                        line metadata write port
// ---------------------------------------------------------------------------
module data_cache_line_store
  import data_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IW    = 4,
  parameter int TW    = 55
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [IW-1:0]       rd_idx_i,
  input  logic [DC_OFF_W-1:0] rd_off_i,
  output logic [63:0]         rd_word_o,
  output logic [TW-1:0]       rd_tag_o,
  output logic                rd_valid_o,
  output logic                rd_dirty_o,
  input  logic                wr_en_i,
  input  logic [IW-1:0]       wr_idx_i,
  input  logic [DC_OFF_W-1:0] wr_off_i,
  input  logic [63:0]         wr_data_i,
  input  logic                meta_we_i,
  input  logic [IW-1:0]       meta_idx_i,
  input  logic [TW-1:0]       meta_tag_i,
  input  logic                meta_valid_i,
  input  logic                meta_dirty_i
);

  logic [63:0]    data_q [LINES][DC_WORDS];
  logic [TW-1:0]  tag_q  [LINES];
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;

  assign rd_word_o  = data_q[rd_idx_i][rd_off_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (meta_we_i) begin
      tag_q[meta_idx_i] <= meta_tag_i;
    end
  end

  // Reset has priority so a line whose final refill ack coincides with
  // reset still ends up invalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we_i) begin
      valid_q[meta_idx_i] <= meta_valid_i;
      dirty_q[meta_idx_i] <= meta_dirty_i;
    end
  end

endmodule

// File: rtl/data_cache.sv
// ---------------------------------------------------------------------------
// data_cache
// Direct-mapped, write-back, write-allocate data cache for the memory stage.
// Hits (load or store) complete with no stall; a miss raises busy_o while the
// controller writes back a dirty victim (WB) and refills the line (REFILL)
// one word at a time, then the live request is looked up again and hits.
//
// Ports
//   clk_i, rst_i      : clock, synchronous active-high reset
//   req_valid_i       : access request this cycle
//   req_we_i          : 1 = store, 0 = load
//   req_addr_i        : byte address (must be 8-byte aligned, < MEM_BYTES)
//   req_wdata_i       : store data
//   rdata_o           : load data (0 unless a valid load hit in IDLE)
//   busy_o            : stall request to the pipeline
//   error_o           : address error (misaligned or out of range)
//   mem_req_o ... mem_wdata_o : word request to backing memory
//   mem_ack_i, mem_rdata_i    : word completion and read data
//   dbg_state_o       : current controller state, for observation only
//
// Backing-memory handshake: mem_req_o acts as valid and mem_ack_i as ready.
// A word transfers at the edge where both are high; until then the request,
// direction, address and write data are held stable. The next word may be
// requested in the cycle right after an ack. An ack without a request is
// ignored.
// ---------------------------------------------------------------------------
module data_cache
  import data_cache_pkg::*;
#(
  parameter int LINES     = 16,
  parameter int MEM_BYTES = 8192
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic [63:0] rdata_o,
  output logic        busy_o,
  output logic        error_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [63:0] mem_rdata_i,
  output logic [1:0]  dbg_state_o
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 64 - DC_IDX_LSB - IW;

  // Controller registers
  dc_state_e           state_q, state_d;
  logic [DC_OFF_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]       miss_tag_q, miss_tag_d;
  logic [IW-1:0]       miss_idx_q, miss_idx_d;

  // Request address decode
  logic [DC_OFF_W-1:0] req_off;
  logic [IW-1:0]       req_idx;
  logic [TW-1:0]       req_tag;
  logic                addr_bad;
  logic                req_ok;
  logic                hit;
  logic                miss;
  logic                last_word;

  // Line store interface
  logic [IW-1:0]       rd_idx;
  logic [DC_OFF_W-1:0] rd_off;
  logic [63:0]         rd_word;
  logic [TW-1:0]       rd_tag;
  logic                rd_valid;
  logic                rd_dirty;
  logic                wr_en;
  logic [IW-1:0]       wr_idx;
  logic [DC_OFF_W-1:0] wr_off;
  logic [63:0]         wr_data;
  logic                meta_we;
  logic [IW-1:0]       meta_idx;
  logic [TW-1:0]       meta_tag;
  logic                meta_valid;
  logic                meta_dirty;

  assign req_off  = req_addr_i[DC_IDX_LSB-1:DC_OFF_LSB];
  assign req_idx  = req_addr_i[DC_IDX_LSB+IW-1:DC_IDX_LSB];
  assign req_tag  = req_addr_i[63:DC_IDX_LSB+IW];
  assign addr_bad = (req_addr_i >= 64'(MEM_BYTES)) || (req_addr_i[2:0] != 3'b000);
  assign req_ok   = req_valid_i && !addr_bad;

  // In IDLE the single read port looks at the live request; during WB and
  // REFILL it looks at the latched miss line, word cnt (victim data for WB).
  assign rd_idx = (state_q == DC_IDLE) ? req_idx : miss_idx_q;
  assign rd_off = (state_q == DC_IDLE) ? req_off : cnt_q;

  assign hit       = (state_q == DC_IDLE) && req_ok && rd_valid && (rd_tag == req_tag);
  assign miss      = (state_q == DC_IDLE) && req_ok && !hit;
  assign last_word = (cnt_q == 2'd3);

  assign dbg_state_o = state_q;

  data_cache_line_store #(
    .LINES (LINES),
    .IW    (IW),
    .TW    (TW)
  ) u_store (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rd_idx_i     (rd_idx),
    .rd_off_i     (rd_off),
    .rd_word_o    (rd_word),
    .rd_tag_o     (rd_tag),
    .rd_valid_o   (rd_valid),
    .rd_dirty_o   (rd_dirty),
    .wr_en_i      (wr_en),
    .wr_idx_i     (wr_idx),
    .wr_off_i     (wr_off),
    .wr_data_i    (wr_data),
    .meta_we_i    (meta_we),
    .meta_idx_i   (meta_idx),
    .meta_tag_i   (meta_tag),
    .meta_valid_i (meta_valid),
    .meta_dirty_i (meta_dirty)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= DC_IDLE;
      cnt_q      <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    case (state_q)
      DC_IDLE: begin
        if (miss) begin
          miss_tag_d = req_tag;
          miss_idx_d = req_idx;
          cnt_d      = '0;
          // rd_* reflect the victim line at req_idx here
          state_d    = (rd_valid && rd_dirty) ? DC_WB : DC_REFILL;
        end
      end
      DC_WB: begin
        if (mem_ack_i) begin
          cnt_d = cnt_q + 2'd1;  // wraps 3 -> 0 at phase end
          if (last_word) state_d = DC_REFILL;
        end
      end
      DC_REFILL: begin
        if (mem_ack_i) begin
          cnt_d = cnt_q + 2'd1;
          if (last_word) state_d = DC_IDLE;
        end
      end
      default: state_d = DC_IDLE;
    endcase
  end

  // Output and array-control logic
  always_comb begin
    rdata_o     = '0;
    busy_o      = 1'b0;
    error_o     = req_valid_i && addr_bad;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    wr_en       = 1'b0;
    wr_idx      = req_idx;
    wr_off      = req_off;
    wr_data     = req_wdata_i;
    meta_we     = 1'b0;
    meta_idx    = req_idx;
    meta_tag    = req_tag;
    meta_valid  = 1'b1;
    meta_dirty  = 1'b1;
    case (state_q)
      DC_IDLE: begin
        busy_o = miss;
        if (hit && !req_we_i) begin
          rdata_o = rd_word;
        end
        if (hit && req_we_i) begin
          wr_en   = 1'b1;
          meta_we = 1'b1;  // keeps tag/valid, sets dirty
        end
      end
      DC_WB: begin
        busy_o      = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {rd_tag, miss_idx_q, cnt_q, 3'b000};
        mem_wdata_o = rd_word;
      end
      DC_REFILL: begin
        busy_o     = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {miss_tag_q, miss_idx_q, cnt_q, 3'b000};
        if (mem_ack_i) begin
          wr_en   = 1'b1;
          wr_idx  = miss_idx_q;
          wr_off  = cnt_q;
          wr_data = mem_rdata_i;
          if (last_word) begin
            meta_we    = 1'b1;
            meta_idx   = miss_idx_q;
            meta_tag   = miss_tag_q;
            meta_dirty = 1'b0;
          end
        end
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_data_cache.sv
// ---------------------------------------------------------------------------
// tb_data_cache
// Self-checking bench for data_cache. The reference is a flat memory image
// (ref_mem: the latest value of every word) plus a per-line record of which
// block each line holds and whether it was written. A backing-memory
// responder with programmable wait states services the cache and checks each
// transfer against the queue of transfers the model expects.
// ---------------------------------------------------------------------------
module tb_data_cache;

  localparam int LINES     = 16;
  localparam int MEM_BYTES = 8192;
  localparam int NWORDS    = MEM_BYTES / 8;

  logic        clk;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_we_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [63:0] rdata_o;
  logic        busy_o;
  logic        error_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [63:0] mem_rdata_i;
  logic [1:0]  dbg_state;

  data_cache #(
    .LINES     (LINES),
    .MEM_BYTES (MEM_BYTES)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rdata_o     (rdata_o),
    .busy_o      (busy_o),
    .error_o     (error_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model state ----------------
  logic [63:0] bmem    [NWORDS];  // backing memory contents
  logic [63:0] ref_mem [NWORDS];  // architectural memory image
  logic        m_valid [LINES];
  logic [63:0] m_block [LINES];   // block number (addr >> 9) held by line
  logic        m_dirty [LINES];

  // scoreboard: expected backing-memory transfers in order
  logic [63:0] exp_addr_q[$];
  logic        exp_we_q[$];
  logic [63:0] exp_q[$];          // expected write-back data

  int n_checks;
  int n_errors;
  int fixed_wait;   // >=0: every ack delayed this many cycles; <0: random 0..2
  int wait_total;   // wait cycles inserted during the current access

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- backing-memory responder ----------------
  initial begin : responder
    int          wcnt;
    int          cur_wait;
    logic [63:0] hold_addr;
    logic [63:0] hold_wdata;
    logic        hold_we;
    logic [63:0] ea;
    logic        ew;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    wcnt        = 0;
    cur_wait    = 0;
    hold_addr   = '0;
    hold_wdata  = '0;
    hold_we     = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req_o && !rst_i) begin
        if (wcnt == 0) begin
          hold_addr  = mem_addr_o;
          hold_wdata = mem_wdata_o;
          hold_we    = mem_we_o;
          cur_wait   = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
        end else begin
          chk("hold_addr", mem_addr_o, hold_addr);
          chk("hold_wdata", mem_wdata_o, hold_wdata);
          chk("hold_we", 64'(mem_we_o), 64'(hold_we));
        end
        if (wcnt >= cur_wait) begin
          mem_ack_i = 1'b1;
          if (mem_we_o) bmem[mem_addr_o[12:3]] = mem_wdata_o;
          mem_rdata_i = bmem[mem_addr_o[12:3]];
          if (exp_addr_q.size() == 0) begin
            chk("xfer_pending", 64'(exp_addr_q.size()), 64'd1);
          end else begin
            ea = exp_addr_q.pop_front();
            ew = exp_we_q.pop_front();
            chk("mem_addr", mem_addr_o, ea);
            chk("mem_we", 64'(mem_we_o), 64'(ew));
            if (ew && exp_q.size() != 0) chk("wb_data", mem_wdata_o, exp_q.pop_front());
          end
          wcnt = 0;
        end else begin
          mem_ack_i = 1'b0;
          wcnt++;
          wait_total++;
        end
      end else begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        wcnt        = 0;
      end
    end
  end

  // ---------------- driver: one request until it completes ----------------
  task automatic access(input logic we, input logic [63:0] addr, input logic [63:0] wd);
    logic        err;
    logic        hit;
    logic        dv;
    int          idx;
    logic [63:0] blk;
    logic [63:0] a;
    int          busy_cnt;
    int          exp_busy;
    err = (addr >= 64'(MEM_BYTES)) || (addr[2:0] != 3'b000);
    idx = int'(addr[8:5]);
    blk = addr >> 9;
    hit = !err && m_valid[idx] && (m_block[idx] == blk);
    dv  = !err && !hit && m_valid[idx] && m_dirty[idx];
    if (!err && !hit) begin
      if (dv) begin
        for (int k = 0; k < 4; k++) begin
          a = (m_block[idx] << 9) | (64'(idx) << 5) | (64'(k) << 3);
          exp_addr_q.push_back(a);
          exp_we_q.push_back(1'b1);
          exp_q.push_back(ref_mem[a[12:3]]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        a = {addr[63:5], 5'b00000} + 64'(8 * k);
        exp_addr_q.push_back(a);
        exp_we_q.push_back(1'b0);
      end
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wd;
    wait_total  = 0;
    busy_cnt    = 0;
    @(negedge clk);
    while (busy_o === 1'b1 && busy_cnt < 100) begin
      busy_cnt++;
      @(negedge clk);
    end
    exp_busy = (err || hit) ? 0 : 1 + (dv ? 8 : 4) + wait_total;
    chk("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
    chk("error", 64'(error_o), 64'(err));
    if (err) chk("err_mem_req", 64'(mem_req_o), 64'd0);
    if (!we) chk("rdata", rdata_o, err ? 64'd0 : ref_mem[addr[12:3]]);
    if (!err) begin
      chk("xfers_left", 64'(exp_addr_q.size()), 64'd0);
      if (!hit) begin
        m_valid[idx] = 1'b1;
        m_block[idx] = blk;
        m_dirty[idx] = 1'b0;
      end
      if (we) begin
        m_dirty[idx]         = 1'b1;
        ref_mem[addr[12:3]]  = wd;
      end
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_block[i] = '0;
    end
    // anything only held dirty in the cache is lost
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = bmem[i];
    exp_addr_q.delete();
    exp_we_q.delete();
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] ra;
    int          r;
    n_checks    = 0;
    n_errors    = 0;
    fixed_wait  = 0;
    wait_total  = 0;
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    for (int i = 0; i < NWORDS; i++) bmem[i] = {$urandom, $urandom};
    bmem[32] = 64'h0123_4567_89AB_CDEF;  // word at 0x100
    model_reset();

    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_mem_we", 64'(mem_we_o), 64'd0);
    chk("rst_mem_addr", mem_addr_o, 64'd0);
    chk("rst_mem_wdata", mem_wdata_o, 64'd0);
    chk("rst_error", 64'(error_o), 64'd0);
    chk("rst_rdata", rdata_o, 64'd0);

    // cold load, store hit, dirty eviction
    access(1'b0, 64'h100, 64'd0);
    access(1'b1, 64'h108, 64'hDEAD);
    access(1'b0, 64'h300, 64'd0);
    chk("wb_mem_0x108", bmem[33], 64'hDEAD);

    // address errors leave the cache alone
    access(1'b0, 64'h2000, 64'd0);
    access(1'b0, 64'h104, 64'd0);
    access(1'b1, 64'h104, 64'hBAD);
    access(1'b0, 64'h300, 64'd0);

    // two wait states per word
    fixed_wait = 2;
    access(1'b0, 64'h500, 64'd0);
    fixed_wait = 0;

    // store miss allocates, later eviction writes it back
    access(1'b1, 64'h40, 64'h55);
    access(1'b0, 64'h240, 64'd0);
    chk("wb_mem_0x40", bmem[8], 64'h55);

    // reset after the second refill ack of a clean miss
    exp_addr_q.delete();
    exp_we_q.delete();
    for (int k = 0; k < 4; k++) begin
      exp_addr_q.push_back(64'h7C0 + 64'(8 * k));
      exp_we_q.push_back(1'b0);
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = 64'h7C0;
    repeat (3) @(posedge clk);
    #1;
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    @(posedge clk);
    #1 rst_i = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midrst_mem_req", 64'(mem_req_o), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    access(1'b0, 64'h7C0, 64'd0);
    access(1'b0, 64'h100, 64'd0);

    // randomized traffic over a few blocks per line, random wait states
    fixed_wait = -1;
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        ra = 64'(MEM_BYTES) + 64'($urandom_range(0, 255)) * 8;
      end else if (r == 1) begin
        ra = 64'($urandom_range(0, NWORDS - 1)) * 8 + 64'($urandom_range(1, 7));
      end else begin
        ra = (64'($urandom_range(0, 3)) << 9) | (64'($urandom_range(0, 15)) << 5) |
             (64'($urandom_range(0, 3)) << 3);
      end
      access(1'($urandom_range(0, 1)), ra, {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
